hdmi_period_sequencer: RTL and testbench
========================================

# hdmi_period_sequencer

Sits between the video timing generator and the three per-channel TMDS/TERC encoders. It delays raw timing and pixel data through a fixed lookahead. It inserts control-period preambles ahead of every video period. It also schedules data-island periods inside horizontal/vertical blanking and pulls 32-word packets from a packet source with a valid/ready handshake.

## Interface
Parameters:
- ISLAND_EN, 1, 0 disables data-island scheduling (video preambles only).

Ports:
- clk  in  1  pixel clock.
- reset_n  in  1  reset reset_n, asynchronous, active-low; clock clk.
- de_in  in  1  raw display enable from timing generator.
- hsync_in, vsync_in  in  1 each  raw syncs.
- pixel_in  in  24  raw {R,G,B}.
- pkt_data  in  10  island word: [1:0] ch0 bits 3:2, [5:2] ch1 nibble, [9:6] ch2 nibble.
- pkt_valid  in  1  packet word available.
- pkt_ready  out  1  word consumed this cycle when pkt_valid & pkt_ready.
- vde  out  1  video data enable to all encoders.
- ade  out  1  aux data enable to all encoders.
- hsync, vsync  out  1 each  ch0 c0/c1.
- ctl  out  4  CTL3..0; ch1 c0/c1 = ctl[0]/ctl[1], ch2 c0/c1 = ctl[2]/ctl[3].
- pixel  out  24  delayed pixel.
- aux0  out  2  ch0 aux bits 3:2.
- aux1, aux2  out  4 each  ch1/ch2 aux nibbles.
- pkt_underrun  out  1  one-cycle pulse, island word missing.

## Operation
- Delay line: de/hsync/vsync/pixel delayed LOOKAHEAD = 66 cycles, then output register. Taps give future-de visibility.
- blank_run counts consecutive raw de_in = 0 cycles. It saturates at 66 and clears on de_in = 1.
- Video preamble: ctl = 4'b0001 on every cycle where delayed de = 0 and any of the next 10 delayed de samples is 1. vde = delayed de. The downstream encoder itself produces the 2-cycle video guard band.
- Island FSM states: IDLE, PRE, DATA, POST.
  - IDLE→PRE: when ISLAND_EN, pkt_valid, delayed de = 0, and blank_run = 66.
  - PRE: 10 cycles, ctl = 4'b0101.
  - DATA: 32 cycles.
    - ade = 1 and pkt_ready = 1.
    - aux1/aux2 driven from pkt_data in the same cycle.
    - aux0 driven from pkt_data[1:0] 2 cycles later, to match the ch0 encoder alignment.
    - If pkt_valid = 0 in a DATA cycle: nibbles are 0, pkt_underrun pulses, and the word counter still advances. The island length is always 32.
  - POST: 14 cycles (2 trailing guard + 12 control), ctl = 0.
  - POST→IDLE. A new island may start the next cycle if the IDLE conditions hold.
- Total island span is 56 cycles. The 66-cycle reservation guarantees ≥10 cycles for the following video preamble, so islands and video never overlap.
- ctl = 0 in IDLE outside video preambles. FSM ctl values take priority but cannot coincide with a video preamble.
- Outside DATA, aux0/aux1/aux2 = 0.

## Timing
- Every output is registered. Input-to-output latency is 67 cycles for de/syncs/pixel.
- Reset (async): all outputs 0, FSM IDLE, delay line cleared, blank_run = 0, word counter 0.
- Reset mid-island: the island is abandoned with no trailing guard. The packet source must flush its partial packet on reset.
- After reset, no island starts until 66 raw blank cycles have been observed.
- pkt_ready is combinational from FSM state only; it never depends on pkt_valid.
- Same-cycle events: the underrun pulse and the DATA→POST transition may coincide on word 31.

## Structure
- Shared package hdmi_pkg holds:
  - Localparams: LOOKAHEAD = 66, PRE_LEN = 10, ISLAND_LEN = 32, POST_LEN = 14.
  - Codes: VIDEO_PREAMBLE = 4'b0001, ISLAND_PREAMBLE = 4'b0101.
  - FSM state typedef.
- One sub-module, hdmi_delay_line: a parameterised width/depth shift register (27 bits × 66) with a tap output vector for de.

## Test plan
- Reset: hold reset_n low with random inputs → all outputs 0. Release → vde first follows de_in 67 cycles after de_in's first post-reset change.
- Video only, 1280 active/370 blank, pkt_valid = 0 → vde equals de_in delayed 67 cycles. ctl = 0001 exactly on the 10 cycles before each vde rise, otherwise 0. ade never 1.
- Island in 370-cycle blank, 32 words 0x000..0x01F valid throughout → ctl = 0101 for 10 cycles, then ade for 32 cycles with pkt_ready for the same 32 cycles. aux1 = word[5:2] aligned with ade; aux0 = word[1:0] 2 cycles later. Then 14 cycles ctl = 0.
- Short blank (60 cycles), pkt_valid = 1 → no island, pkt_ready never asserted.
- Underrun: pkt_valid low on word 5 only → aux1 = aux2 = 0 on that cycle, one pkt_underrun pulse, ade still exactly 32 cycles.
- Reset asserted at DATA word 10 → outputs 0 immediately. After release, no ade until a fresh 66-cycle blank run.

Source files
------------

// File: rtl/hdmi_pkg.sv
// Shared constants, control-period codes and island FSM state type for the
// HDMI period sequencer.
package hdmi_pkg;

  localparam int LOOKAHEAD     = 66;
  localparam int PRE_LEN       = 10;
  localparam int ISLAND_LEN    = 32;
  localparam int POST_LEN      = 14;
  localparam int VIDEO_PRE_LEN = 10;

  // Delay-line word layout: {de, hsync, vsync, pixel[23:0]}
  localparam int LINE_W      = 27;
  localparam int LINE_DE_BIT = 26;
  localparam int LINE_HS_BIT = 25;
  localparam int LINE_VS_BIT = 24;

  localparam logic [3:0] VIDEO_PREAMBLE  = 4'b0001;
  localparam logic [3:0] ISLAND_PREAMBLE = 4'b0101;
  localparam logic [3:0] CTL_IDLE        = 4'b0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PRE  = 2'd1,
    ST_DATA = 2'd2,
    ST_POST = 2'd3
  } island_state_t;

  // Final value of the per-state cycle counter before leaving that state.
  function automatic logic [5:0] last_count(input island_state_t st);
    logic [5:0] value;
    case (st)
      ST_PRE:  value = 6'(PRE_LEN - 1);
      ST_DATA: value = 6'(ISLAND_LEN - 1);
      ST_POST: value = 6'(POST_LEN - 1);
      default: value = 6'd0;
    endcase
    return value;
  endfunction

endpackage

// File: rtl/hdmi_delay_line.sv
// Fixed-depth shift register for the raw timing/pixel word. Besides the
// fully delayed word it exposes the de bit of the next TAPS samples that
// will reach the output, so the caller can see video coming.
module hdmi_delay_line #(
  parameter int WIDTH   = 27,
  parameter int DEPTH   = 66,
  parameter int TAP_BIT = 26,
  parameter int TAPS    = 10
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [TAPS-1:0]  tap_de
);

  // stage_r[0] holds din delayed by one cycle, stage_r[DEPTH-1] by DEPTH cycles
  logic [WIDTH-1:0] stage_r [DEPTH];

  // Shift one stage per clock; reset empties the whole line
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_r[i] <= {WIDTH{1'b0}};
      end
    end else begin
      stage_r[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        stage_r[i] <= stage_r[i-1];
      end
    end
  end

  assign dout = stage_r[DEPTH-1];

  // tap_de[k] is the de value that will appear at dout k+1 cycles from now
  for (genvar k = 0; k < TAPS; k++) begin : g_tap
    assign tap_de[k] = stage_r[DEPTH-2-k][TAP_BIT];
  end

endmodule

// File: rtl/hdmi_period_sequencer.sv
// HDMI period sequencer: delays timing and pixels by a fixed lookahead,
// inserts video preambles, and schedules data islands in long blanking
// intervals while pulling packet words from a valid/ready source.
// Registered outputs are decoded from the FSM's next state so that ade and
// ctl line up with the state itself; pkt_ready, aux1/aux2 and pkt_underrun
// are decoded from the state register so the consumed word appears in the
// same cycle as ade.
module hdmi_period_sequencer
  import hdmi_pkg::*;
#(
  parameter bit ISLAND_EN = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        de_in,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic [23:0] pixel_in,
  input  logic [9:0]  pkt_data,
  input  logic        pkt_valid,
  output logic        pkt_ready,
  output logic        vde,
  output logic        ade,
  output logic        hsync,
  output logic        vsync,
  output logic [3:0]  ctl,
  output logic [23:0] pixel,
  output logic [1:0]  aux0,
  output logic [3:0]  aux1,
  output logic [3:0]  aux2,
  output logic        pkt_underrun
);

  logic [LINE_W-1:0]        line_in_s;
  logic [LINE_W-1:0]        line_out_s;
  logic [VIDEO_PRE_LEN-1:0] de_future_s;
  logic                     delayed_de_s;
  logic                     preamble_s;
  logic [6:0]               blank_run_r;
  logic                     start_s;
  island_state_t            state_r;
  island_state_t            next_state_s;
  logic [5:0]               cnt_r;
  logic                     in_data_s;
  logic                     word_ok_s;
  logic [3:0]               ctl_next_s;
  logic                     ade_next_s;
  logic [1:0]               aux0_stage_s;
  logic [1:0]               aux0_pipe_r;

  assign line_in_s = {de_in, hsync_in, vsync_in, pixel_in};

  hdmi_delay_line #(
    .WIDTH   (LINE_W),
    .DEPTH   (LOOKAHEAD),
    .TAP_BIT (LINE_DE_BIT),
    .TAPS    (VIDEO_PRE_LEN)
  ) u_delay (
    .clk     (clk),
    .reset_n (reset_n),
    .din     (line_in_s),
    .dout    (line_out_s),
    .tap_de  (de_future_s)
  );

  assign delayed_de_s = line_out_s[LINE_DE_BIT];
  assign preamble_s   = !delayed_de_s && (|de_future_s);
  assign start_s      = ISLAND_EN && pkt_valid && !delayed_de_s &&
                        (blank_run_r == 7'(LOOKAHEAD));
  assign in_data_s    = (state_r == ST_DATA);
  assign word_ok_s    = in_data_s && pkt_valid;
  assign pkt_ready    = in_data_s;

  // Count consecutive raw blank cycles, saturating at the lookahead depth
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blank_run_r <= 7'd0;
    end else if (de_in) begin
      blank_run_r <= 7'd0;
    end else if (blank_run_r != 7'(LOOKAHEAD)) begin
      blank_run_r <= blank_run_r + 7'd1;
    end else begin
      blank_run_r <= blank_run_r;
    end
  end

  // Island FSM state register and per-state cycle/word counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
      cnt_r   <= 6'd0;
    end else begin
      state_r <= next_state_s;
      if (next_state_s != state_r) begin
        cnt_r <= 6'd0;
      end else if (state_r != ST_IDLE) begin
        cnt_r <= cnt_r + 6'd1;
      end else begin
        cnt_r <= 6'd0;
      end
    end
  end

  // Island FSM next-state: fixed-length PRE, DATA and POST phases
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start_s) next_state_s = ST_PRE;
        else         next_state_s = ST_IDLE;
      end
      ST_PRE: begin
        if (cnt_r == last_count(ST_PRE)) next_state_s = ST_DATA;
        else                             next_state_s = ST_PRE;
      end
      ST_DATA: begin
        if (cnt_r == last_count(ST_DATA)) next_state_s = ST_POST;
        else                              next_state_s = ST_DATA;
      end
      ST_POST: begin
        if (cnt_r == last_count(ST_POST)) next_state_s = ST_IDLE;
        else                              next_state_s = ST_POST;
      end
      default: next_state_s = ST_IDLE;
    endcase
  end

  // Output decode: island codes win, video preamble only when idle
  always_comb begin
    ctl_next_s = CTL_IDLE;
    ade_next_s = 1'b0;
    case (next_state_s)
      ST_PRE:  ctl_next_s = ISLAND_PREAMBLE;
      ST_DATA: ade_next_s = 1'b1;
      ST_POST: ctl_next_s = CTL_IDLE;
      ST_IDLE: begin
        if (preamble_s) ctl_next_s = VIDEO_PREAMBLE;
        else            ctl_next_s = CTL_IDLE;
      end
      default: ctl_next_s = CTL_IDLE;
    endcase
  end

  // Same-cycle island word fan-out; a missing word sends zero nibbles
  always_comb begin
    aux1         = 4'd0;
    aux2         = 4'd0;
    aux0_stage_s = 2'd0;
    pkt_underrun = 1'b0;
    if (word_ok_s) begin
      aux1         = pkt_data[5:2];
      aux2         = pkt_data[9:6];
      aux0_stage_s = pkt_data[1:0];
    end else begin
      pkt_underrun = in_data_s;
    end
  end

  // Output registers: delayed video path, control codes, ch0 aux pipeline
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vde         <= 1'b0;
      hsync       <= 1'b0;
      vsync       <= 1'b0;
      pixel       <= 24'd0;
      ctl         <= 4'd0;
      ade         <= 1'b0;
      aux0_pipe_r <= 2'd0;
      aux0        <= 2'd0;
    end else begin
      vde         <= delayed_de_s;
      hsync       <= line_out_s[LINE_HS_BIT];
      vsync       <= line_out_s[LINE_VS_BIT];
      pixel       <= line_out_s[23:0];
      ctl         <= ctl_next_s;
      ade         <= ade_next_s;
      aux0_pipe_r <= aux0_stage_s;
      aux0        <= aux0_pipe_r;
    end
  end

endmodule

// File: tb/tb_hdmi_period_sequencer.sv
// Bench for hdmi_period_sequencer: a history-based reference model derives
// every output from the recorded inputs, plus literal per-phase expectations.
module tb_hdmi_period_sequencer;

  localparam int MAXC      = 20000;
  localparam bit ISLAND_EN = 1'b1;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        de_in, hsync_in, vsync_in;
  logic [23:0] pixel_in;
  logic [9:0]  pkt_data;
  logic        pkt_valid;
  logic        pkt_ready, vde, ade, hsync, vsync, pkt_underrun;
  logic [3:0]  ctl, aux1, aux2;
  logic [23:0] pixel;
  logic [1:0]  aux0;

  always #5 clk = ~clk;

  hdmi_period_sequencer #(.ISLAND_EN(ISLAND_EN)) dut (
    .clk(clk), .reset_n(reset_n), .de_in(de_in), .hsync_in(hsync_in),
    .vsync_in(vsync_in), .pixel_in(pixel_in), .pkt_data(pkt_data),
    .pkt_valid(pkt_valid), .pkt_ready(pkt_ready), .vde(vde), .ade(ade),
    .hsync(hsync), .vsync(vsync), .ctl(ctl), .pixel(pixel), .aux0(aux0),
    .aux1(aux1), .aux2(aux2), .pkt_underrun(pkt_underrun)
  );

  // recorded inputs, indexed by the cycle in which they were presented
  logic [26:0] h_line [MAXC];
  logic        h_val  [MAXC];
  logic [9:0]  h_dat  [MAXC];

  int cyc        = 0;
  int valid_from = 0;
  int isl_start  = -1000;
  int errors     = 0;
  int checks     = 0;

  // packet source
  logic       src_en   = 1'b0;
  int         src_slot = 0;
  int         src_skip = -1;
  logic [9:0] src_base = 10'd0;

  // per-phase statistics taken from DUT outputs
  int n_ade, n_ready, n_pre_isl, n_pre_vid, n_under, first_ade, first_vde, c7;
  logic [7:0] cap5, cap7;
  logic [1:0] cap_a0;
  logic       vs_lvl = 1'b0;

  task automatic clear_stats();
    n_ade = 0; n_ready = 0; n_pre_isl = 0; n_pre_vid = 0; n_under = 0;
    first_ade = -1; first_vde = -1; c7 = -100;
    cap5 = 8'hxx; cap7 = 8'hxx; cap_a0 = 2'bxx;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // input word at cycle i as seen by the DUT (nothing before the last reset)
  function automatic logic [26:0] eff_line(input int i);
    if (i < 0 || i < valid_from) return 27'd0;
    return h_line[i];
  endfunction

  // true when cycles c-66 .. c-1 were all captured and all blank
  function automatic bit blank_ok(input int c);
    if (c - 66 < valid_from || c - 66 < 0) return 1'b0;
    for (int i = c - 66; i < c; i++) begin
      if (h_line[i][26]) return 1'b0;
    end
    return 1'b1;
  endfunction

  // one clock: drive inputs at negedge, sample #1 later, compare with model
  task automatic step(input logic de, input logic hs, input logic vs,
                      input logic [23:0] px, input logic rst);
    logic [26:0] e_line;
    logic [3:0]  e_ctl, e_a1, e_a2;
    logic [1:0]  e_a0;
    logic        pre, in_data, e_und;
    int          o;
    @(negedge clk);
    reset_n   = ~rst;
    de_in     = de;
    hsync_in  = hs;
    vsync_in  = vs;
    pixel_in  = px;
    pkt_valid = src_en && (src_slot < 32) && (src_slot != src_skip);
    pkt_data  = src_base + src_slot[9:0];
    h_line[cyc] = {de, hs, vs, px};
    h_val[cyc]  = pkt_valid;
    h_dat[cyc]  = pkt_data;
    if (rst) begin
      valid_from = cyc + 1;
      isl_start  = -1000;
    end
    #1;
    e_line = 27'd0; e_ctl = 4'd0; e_a0 = 2'd0; e_a1 = 4'd0; e_a2 = 4'd0;
    in_data = 1'b0; e_und = 1'b0;
    if (!rst) begin
      e_line = eff_line(cyc - 67);
      pre = 1'b0;
      if (!e_line[26]) begin
        for (int k = 57; k <= 66; k++) begin
          if (eff_line(cyc - k)[26]) pre = 1'b1;
        end
      end
      o = cyc - isl_start;
      if (o >= 1 && o <= 10)       e_ctl = 4'b0101;
      else if (o >= 11 && o <= 56) e_ctl = 4'b0000;
      else if (pre)                e_ctl = 4'b0001;
      else                         e_ctl = 4'b0000;
      in_data = (o >= 11 && o <= 42);
      e_und   = in_data && !h_val[cyc];
      if (in_data && h_val[cyc]) begin
        e_a1 = h_dat[cyc][5:2];
        e_a2 = h_dat[cyc][9:6];
      end
      if (o >= 13 && o <= 44 && h_val[cyc-2]) e_a0 = h_dat[cyc-2][1:0];
    end
    check("video", 64'({vde, hsync, vsync, pixel}), 64'(e_line));
    check("ctl", 64'(ctl), 64'(e_ctl));
    check("island", 64'({ade, pkt_ready, pkt_underrun, aux0, aux1, aux2}),
          64'({in_data, in_data, e_und, e_a0, e_a1, e_a2}));
    // model: does an island get scheduled this cycle?
    if (!rst && ISLAND_EN && h_val[cyc] && cyc >= isl_start + 57 && blank_ok(cyc))
      isl_start = cyc;
    // statistics
    if (vde && first_vde < 0) first_vde = cyc;
    if (ctl == 4'b0101) n_pre_isl++;
    if (ctl == 4'b0001) n_pre_vid++;
    if (pkt_ready) n_ready++;
    if (pkt_underrun) n_under++;
    if (ade) begin
      if (first_ade < 0) first_ade = cyc;
      if (n_ade == 5) cap5 = {aux2, aux1};
      if (n_ade == 7) begin cap7 = {aux2, aux1}; c7 = cyc; end
      n_ade++;
    end
    if (cyc == c7 + 2) cap_a0 = aux0;
    // packet source advances on every consumed slot
    if (pkt_ready) src_slot++;
    cyc++;
  endtask

  task automatic line(input int active, input int blank, input logic en);
    src_en = 1'b0;
    for (int i = 0; i < active; i++) begin
      if (i == 1 && en) begin src_en = 1'b1; src_slot = 0; end
      step(1'b1, 1'b0, vs_lvl, 24'($urandom), 1'b0);
    end
    for (int i = 0; i < blank; i++)
      step(1'b0, (i >= 10 && i < 50), vs_lvl, 24'd0, 1'b0);
    vs_lvl = ~vs_lvl;
  endtask

  int rel, bstart;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_stats();
    // reset with random inputs
    src_en = 1'b1; src_base = 10'($urandom);
    for (int i = 0; i < 5; i++)
      step(1'($urandom), 1'($urandom), 1'($urandom), 24'($urandom), 1'b1);
    check("reset_outputs", 64'({vde, ade, ctl, pkt_ready, pixel}), 64'd0);

    // video only
    src_en = 1'b0; src_base = 10'd0;
    clear_stats();
    rel = cyc;
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 1'b0, 24'd0, 1'b0);
    line(1280, 370, 1'b0);
    line(1280, 370, 1'b0);
    check("first_vde_latency", 64'(first_vde), 64'(rel + 20 + 67));
    check("video_preamble_cycles", 64'(n_pre_vid), 64'd20);
    check("video_only_no_ade", 64'(n_ade), 64'd0);

    // one island with words 0x000..0x01F
    clear_stats();
    bstart = cyc;
    line(1280, 370, 1'b1);
    check("island_first_ade", 64'(first_ade), 64'(bstart + 1280 + 77));
    check("island_ade_len", 64'(n_ade), 64'd32);
    check("island_ready_len", 64'(n_ready), 64'd32);
    check("island_preamble_len", 64'(n_pre_isl), 64'd10);
    check("island_word7_nibbles", 64'(cap7), 64'h01);
    check("island_word7_aux0", 64'(cap_a0), 64'd3);

    // underrun on word 5
    clear_stats();
    src_base = 10'h3C0; src_skip = 5;
    line(1280, 370, 1'b1);
    check("underrun_pulses", 64'(n_under), 64'd1);
    check("underrun_ade_len", 64'(n_ade), 64'd32);
    check("underrun_word5_nibbles", 64'(cap5), 64'h00);
    check("underrun_word7_nibbles", 64'(cap7), 64'hF1);
    check("underrun_word7_aux0", 64'(cap_a0), 64'd3);
    src_skip = -1;

    // short blanking: no island
    clear_stats();
    src_base = 10'h055;
    for (int l = 0; l < 3; l++) line(1280, 60, 1'b1);
    check("short_blank_no_ready", 64'(n_ready), 64'd0);
    check("short_blank_no_ade", 64'(n_ade), 64'd0);

    // reset at DATA word 10
    src_base = 10'h100;
    src_en = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (i == 1) begin src_en = 1'b1; src_slot = 0; end
      step(1'b1, 1'b0, 1'b0, 24'($urandom), 1'b0);
    end
    for (int i = 0; i < 1000 && src_slot < 10; i++)
      step(1'b0, 1'b0, 1'b0, 24'd0, 1'b0);
    check("reach_word10", 64'(src_slot), 64'd10);
    step(1'b0, 1'b0, 1'b0, 24'd0, 1'b1);
    check("reset_mid_island", 64'({ade, pkt_ready, ctl, aux1, aux2, aux0}), 64'd0);
    step(1'b0, 1'b0, 1'b0, 24'd0, 1'b1);
    src_slot = 0;
    step(1'b0, 1'b0, 1'b0, 24'd0, 1'b1);
    clear_stats();
    rel = cyc;
    for (int i = 0; i < 150; i++) step(1'b0, 1'b0, 1'b0, 24'd0, 1'b0);
    check("post_reset_first_ade", 64'(first_ade), 64'(rel + 77));
    check("post_reset_ade_len", 64'(n_ade), 64'd32);
    src_en = 1'b0;
    for (int i = 0; i < 100; i++) step(1'b1, 1'b0, 1'b0, 24'($urandom), 1'b0);
    for (int i = 0; i < 100; i++) step(1'b0, 1'b0, 1'b0, 24'd0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
